fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ROM_WIDTH, default 21, instruction word width.
REQ-002 Parameter STACK_DEPTH, default 8, return-address stack entries.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 stall  input  1  1 = hold all state, no issue.
REQ-006 zero_flag  input  1  accumulator-zero flag from execute stage.
REQ-007 rom_addr  output  16  program counter driven to instruction ROM ADDR.
REQ-008 rom_data  input  ROM_WIDTH  instruction from asynchronous ROM for rom_addr.
REQ-009 instr  output  ROM_WIDTH  registered instruction issued to execute stage.
REQ-010 instr_valid  output  1  instr valid this cycle.
REQ-011 halted  output  1  stop condition reached.
REQ-012 fault  output  1  stack overflow/underflow detected.

Function
REQ-013 Word format SHALL be opcode = rom_data[20:16], operand = rom_data[15:0].
REQ-014 Flow opcodes SHALL be JMP 5'b01001, JZ 5'b01010, CALL 5'b01101, RET 5'b10001; all others are data instructions.
REQ-015 rom_addr SHALL equal the PC register directly, no combinational path from rom_data.
REQ-016 States SHALL be RUN, JZ_WAIT, HALT, FAULT.
REQ-017 RUN, data instruction, stall=0: instr<=rom_data, instr_valid<=1, PC<=PC+1 (16-bit wrap 0xFFFF->0x0000).
REQ-018 Flow instructions SHALL execute inside this block and never be issued: instr_valid<=0 that cycle.
REQ-019 JMP: PC<=operand; if operand==PC, go HALT instead (stop idiom).
REQ-020 CALL: push PC+1, PC<=operand; if stack full, go FAULT, PC and stack unchanged.
REQ-021 RET: pop, PC<=popped value; if stack empty, go FAULT, PC unchanged.
REQ-022 JZ when instr_valid==1 this cycle (previous instruction still in execute): go JZ_WAIT, PC unchanged, instr_valid<=0.
REQ-023 JZ when instr_valid==0, or in JZ_WAIT: PC<=operand if zero_flag==1 else PC+1; return to RUN.
REQ-024 JZ branch latency: 1 cycle normally, 2 cycles directly after an issued data instruction.
REQ-025 stall=1 SHALL freeze PC, state, stack, instr, instr_valid.
REQ-026 HALT and FAULT SHALL be terminal until reset: PC frozen, instr_valid=0, halted=1 or fault=1 respectively.
REQ-027 CALL fills to exactly STACK_DEPTH entries without fault; CALL number STACK_DEPTH+1 faults.

Reset
REQ-028 rst_n=0 SHALL immediately force PC=0, state RUN, stack pointer 0, instr=0, instr_valid=0, halted=0, fault=0, regardless of clock or current operation.
REQ-029 Release of rst_n SHALL first fetch address 0x0000 on the next rising edge.
REQ-030 Stack contents need not be cleared; only the pointer.

Structure
REQ-031 Shared package cpu_pkg SHALL hold opcode constants, OPCODE_W=5, ADDR_W=16, ROM_WIDTH default.
REQ-032 Return stack SHALL be a sub-module ret_stack (push, pop, full, empty, top, 16-bit data, depth STACK_DEPTH).
REQ-033 State encoding SHALL be a localparam enum in fetch_sequencer.

Verification
REQ-034 Reset release with ROM "a=5" at 0 -> rom_addr 0x0000, next cycle instr=0x1D0005, instr_valid=1, rom_addr=0x0001.
REQ-035 CALL 0x0013 at PC 0x0004 -> rom_addr 0x0013, depth 1, instr_valid=0; later RET -> rom_addr 0x0005, depth 0.
REQ-036 "--a" then JZ 0x001E with zero_flag=1 -> one JZ_WAIT cycle, then rom_addr 0x001E; with zero_flag=0 -> 0x001D.
REQ-037 JMP 0x000F at PC 0x000F -> halted=1, rom_addr stays 0x000F, instr_valid=0 for 10+ cycles.
REQ-038 9 nested CALLs (depth 8) -> fault=1 on 9th, rom_addr = 9th CALL address; RET from empty stack after reset -> fault=1.
REQ-039 stall=1 for 3 cycles mid-loop, then rst_n=0 asynchronously mid-cycle -> outputs frozen during stall, then instantly rom_addr=0, instr_valid=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the fetch front end: instruction field widths and flow-control opcodes.
package cpu_pkg;

  localparam int OPCODE_W      = 5;
  localparam int ADDR_W        = 16;
  localparam int ROM_WIDTH_DEF = OPCODE_W + ADDR_W;

  localparam logic [OPCODE_W-1:0] OP_JMP  = 5'b01001;
  localparam logic [OPCODE_W-1:0] OP_JZ   = 5'b01010;
  localparam logic [OPCODE_W-1:0] OP_CALL = 5'b01101;
  localparam logic [OPCODE_W-1:0] OP_RET  = 5'b10001;

  function automatic logic is_flow_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_JMP) || (op == OP_JZ) || (op == OP_CALL) || (op == OP_RET);
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address stack: the pointer resets, the storage does not.
module ret_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] top,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] FULL_LVL = PTR_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  sp_q, sp_d;
  logic [PTR_W-1:0]  sp_dec;
  logic              do_push, do_pop;

  assign full    = (sp_q == FULL_LVL);
  assign empty   = (sp_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign sp_dec  = sp_q - PTR_W'(1);
  assign top     = mem_q[IDX_W'(sp_dec)];

  always_comb begin
    sp_d = sp_q;
    if (do_push)     sp_d = sp_q + PTR_W'(1);
    else if (do_pop) sp_d = sp_dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= '0;
    else        sp_q <= sp_d;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[IDX_W'(sp_q)] <= push_data;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing: issues data instructions, executes JMP/JZ/CALL/RET internally.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int ROM_WIDTH   = ROM_WIDTH_DEF,
  parameter int STACK_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 zero_flag,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [ROM_WIDTH-1:0] rom_data,
  output logic [ROM_WIDTH-1:0] instr,
  output logic                 instr_valid,
  output logic                 halted,
  output logic                 fault
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_JZ_WAIT = 2'd1,
    ST_HALT    = 2'd2,
    ST_FAULT   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d, pc_inc;
  logic [ROM_WIDTH-1:0] instr_q, instr_d;
  logic                 instr_valid_q, instr_valid_d;
  logic                 halted_q, halted_d;
  logic                 fault_q, fault_d;

  logic [OPCODE_W-1:0]  opcode;
  logic [ADDR_W-1:0]    operand;
  logic                 stk_push, stk_pop, stk_full, stk_empty;
  logic [ADDR_W-1:0]    stk_top;

  assign opcode      = rom_data[ADDR_W +: OPCODE_W];
  assign operand     = rom_data[ADDR_W-1:0];
  assign pc_inc      = pc_q + ADDR_W'(1);

  assign rom_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign fault       = fault_q;

  ret_stack #(
    .DEPTH  (STACK_DEPTH),
    .DATA_W (ADDR_W)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    fault_d       = fault_q;
    stk_push      = 1'b0;
    stk_pop       = 1'b0;

    if (!stall) begin
      instr_valid_d = 1'b0;
      case (state_q)
        ST_RUN: begin
          if (!is_flow_op(opcode)) begin
            instr_d       = rom_data;
            instr_valid_d = 1'b1;
            pc_d          = pc_inc;
          end else if (opcode == OP_JMP) begin
            // A jump to itself is the program's way of saying "stop".
            if (operand == pc_q) begin
              state_d  = ST_HALT;
              halted_d = 1'b1;
            end else begin
              pc_d = operand;
            end
          end else if (opcode == OP_JZ) begin
            // zero_flag is stale while the previous instruction is still executing.
            if (instr_valid_q) state_d = ST_JZ_WAIT;
            else               pc_d    = zero_flag ? operand : pc_inc;
          end else if (opcode == OP_CALL) begin
            if (stk_full) begin
              state_d = ST_FAULT;
              fault_d = 1'b1;
            end else begin
              stk_push = 1'b1;
              pc_d     = operand;
            end
          end else begin
            if (stk_empty) begin
              state_d = ST_FAULT;
              fault_d = 1'b1;
            end else begin
              stk_pop = 1'b1;
              pc_d    = stk_top;
            end
          end
        end
        ST_JZ_WAIT: begin
          pc_d    = zero_flag ? operand : pc_inc;
          state_d = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      pc_q          <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      fault_q       <= fault_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small behavioural ROM.
module tb_fetch_sequencer;

  localparam logic [4:0] JMP  = 5'b01001;
  localparam logic [4:0] JZ   = 5'b01010;
  localparam logic [4:0] CALL = 5'b01101;
  localparam logic [4:0] RET  = 5'b10001;
  localparam logic [4:0] DAT  = 5'h1D;
  localparam logic [4:0] DEC  = 5'h1E;

  logic        clk = 1'b0;
  logic        rst_n, stall, zero_flag;
  logic [15:0] rom_addr;
  logic [20:0] rom_data, instr;
  logic        instr_valid, halted, fault;
  logic [20:0] rom [256];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr[7:0]];

  fetch_sequencer #(.ROM_WIDTH(21), .STACK_DEPTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .zero_flag   (zero_flag),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .halted      (halted),
    .fault       (fault)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  function automatic logic [20:0] w(input logic [4:0] op, input logic [15:0] a);
    return {op, a};
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    stall     = 1'b0;
    zero_flag = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    stall     = 1'b0;
    zero_flag = 1'b0;
    clear_rom();

    // Reset state and first fetch
    rom[0] = 21'h1D0005;
    do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_addr", rom_addr, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", instr_valid, 32'h0);
    check("rst_halt", halted, 32'h0);
    check("rst_fault", fault, 32'h0);
    step(1);
    rst_n = 1'b1;
    #2;
    check("rel_addr", rom_addr, 32'h0);
    step(1);
    check("first_instr", instr, 32'h1D0005);
    check("first_valid", instr_valid, 32'h1);
    check("first_addr", rom_addr, 32'h1);

    // CALL / RET
    clear_rom();
    for (int i = 0; i < 4; i++) rom[i] = w(DAT, 16'(i + 1));
    rom[4]    = w(CALL, 16'h0013);
    rom[8'h13] = w(DAT, 16'h0077);
    rom[8'h14] = w(RET, 16'h0000);
    do_reset();
    step(4);
    check("pre_call_addr", rom_addr, 32'h4);
    check("pre_call_instr", instr, 32'h1D0004);
    step(1);
    check("call_addr", rom_addr, 32'h13);
    check("call_depth", dut.u_stack.sp_q, 32'h1);
    check("call_valid", instr_valid, 32'h0);
    step(1);
    check("callee_instr", instr, 32'h1D0077);
    check("callee_addr", rom_addr, 32'h14);
    step(1);
    check("ret_addr", rom_addr, 32'h5);
    check("ret_depth", dut.u_stack.sp_q, 32'h0);
    check("ret_valid", instr_valid, 32'h0);

    // JZ after an issued instruction, taken then not taken; then a direct JZ
    for (int zf = 1; zf >= 0; zf--) begin
      clear_rom();
      rom[0]     = w(JMP, 16'h001B);
      rom[8'h1B] = w(DEC, 16'h0000);
      rom[8'h1C] = w(JZ, 16'h001E);
      rom[8'h1E] = w(JZ, 16'h0030);
      do_reset();
      zero_flag = zf[0];
      step(1);
      check("jmp_addr", rom_addr, 32'h1B);
      check("jmp_valid", instr_valid, 32'h0);
      step(1);
      check("dec_valid", instr_valid, 32'h1);
      check("dec_addr", rom_addr, 32'h1C);
      step(1);
      check("jzwait_addr", rom_addr, 32'h1C);
      check("jzwait_valid", instr_valid, 32'h0);
      step(1);
      check("jz_target", rom_addr, zf ? 32'h1E : 32'h1D);
      if (zf == 1) begin
        step(1);
        check("jz_direct", rom_addr, 32'h30);
      end
    end

    // PC wraps from 0xFFFF to 0x0000
    clear_rom();
    rom[0]     = w(JMP, 16'hFFFF);
    rom[8'hFF] = 21'h1D00AA;
    do_reset();
    step(1);
    check("wrap_pre", rom_addr, 32'hFFFF);
    step(1);
    check("wrap_addr", rom_addr, 32'h0);
    check("wrap_instr", instr, 32'h1D00AA);

    // Stop idiom
    clear_rom();
    rom[0]     = w(JMP, 16'h000F);
    rom[8'h0F] = w(JMP, 16'h000F);
    do_reset();
    step(1);
    check("halt_pre", halted, 32'h0);
    step(1);
    check("halt_set", halted, 32'h1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("halt_addr", rom_addr, 32'hF);
      check("halt_valid", instr_valid, 32'h0);
      check("halt_hold", halted, 32'h1);
    end

    // Stack overflow on the ninth nested CALL
    clear_rom();
    for (int i = 0; i < 9; i++) rom[i] = w(CALL, 16'(i + 1));
    do_reset();
    step(8);
    check("full_depth", dut.u_stack.sp_q, 32'h8);
    check("full_nofault", fault, 32'h0);
    check("full_addr", rom_addr, 32'h8);
    step(1);
    check("ovf_fault", fault, 32'h1);
    check("ovf_addr", rom_addr, 32'h8);
    check("ovf_depth", dut.u_stack.sp_q, 32'h8);
    step(3);
    check("ovf_hold_addr", rom_addr, 32'h8);
    check("ovf_hold_valid", instr_valid, 32'h0);
    check("ovf_hold_fault", fault, 32'h1);

    // Underflow on RET straight after reset
    clear_rom();
    rom[0] = w(RET, 16'h0000);
    do_reset();
    step(1);
    check("unf_fault", fault, 32'h1);
    check("unf_addr", rom_addr, 32'h0);
    check("unf_halt", halted, 32'h0);

    // Stall mid-loop, then asynchronous reset mid-cycle
    clear_rom();
    rom[0] = 21'h1D0001;
    rom[1] = 21'h1D0002;
    rom[2] = w(JMP, 16'h0000);
    do_reset();
    step(3);
    check("loop_back", rom_addr, 32'h0);
    step(1);
    check("loop_addr", rom_addr, 32'h1);
    check("loop_instr", instr, 32'h1D0001);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("stall_addr", rom_addr, 32'h1);
      check("stall_instr", instr, 32'h1D0001);
      check("stall_valid", instr_valid, 32'h1);
    end
    stall = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_addr", rom_addr, 32'h0);
    check("async_valid", instr_valid, 32'h0);
    check("async_instr", instr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
